// File: rtl/alu_issue_ctrl_if.sv
// Handshake and ALU-side bundle between decode, the issue controller and the combinational ALU.
// The slave view is the controller; the master view is whatever drives requests and models the ALU.
interface alu_issue_ctrl_if #(
    parameter int W = 64
);
    logic         req_valid;
    logic         req_ready;
    logic [3:0]   req_op;
    logic [3:0]   req_cond;
    logic [W-1:0] req_a;
    logic [W-1:0] req_b;

    logic [W-1:0] alu_a;
    logic [W-1:0] alu_b;
    logic [4:0]   alu_fs;
    logic         alu_c0;
    logic [W-1:0] alu_f;
    logic [3:0]   alu_status;

    logic         rsp_valid;
    logic         rsp_ready;
    logic [W-1:0] rsp_result;
    logic         rsp_we;
    logic         rsp_taken;
    logic         rsp_err;

    modport slave (
        input  req_valid, req_op, req_cond, req_a, req_b, alu_f, alu_status, rsp_ready,
        output req_ready, alu_a, alu_b, alu_fs, alu_c0,
        output rsp_valid, rsp_result, rsp_we, rsp_taken, rsp_err
    );

    modport master (
        output req_valid, req_op, req_cond, req_a, req_b, alu_f, alu_status, rsp_ready,
        input  req_ready, alu_a, alu_b, alu_fs, alu_c0,
        input  rsp_valid, rsp_result, rsp_we, rsp_taken, rsp_err
    );
endinterface

// File: rtl/alu_issue_ctrl.sv
// Issue controller for the LEGv8 ALU: decodes an op into (FS, C0), registers operands,
// captures the ALU result and status one cycle later and holds the response until taken.
module alu_issue_ctrl #(
    parameter int W = 64
) (
    input  logic             clock,
    input  logic             reset,
    alu_issue_ctrl_if.slave  bus,
    output logic [3:0]       flags
);
    typedef enum logic [1:0] {S_IDLE, S_EXEC, S_RESP} state_t;

    typedef struct packed {
        logic [4:0] fs;
        logic       c0;
        logic       we;
        logic       setf;
        logic       logic_flags;
        logic       bcond;
        logic       illegal;
    } dec_t;

    function automatic dec_t decode(input logic [3:0] op);
        dec_t d;
        d = '0;
        case (op)
            4'd0:  begin d.fs = 5'b01100; d.we = 1'b1; end
            4'd1:  begin d.fs = 5'b01110; d.c0 = 1'b1; d.we = 1'b1; end
            4'd2:  begin d.fs = 5'b00000; d.we = 1'b1; end
            4'd3:  begin d.fs = 5'b00100; d.we = 1'b1; end
            4'd4:  begin d.fs = 5'b01000; d.we = 1'b1; end
            4'd5:  begin d.fs = 5'b10000; d.we = 1'b1; end
            4'd6:  begin d.fs = 5'b10100; d.we = 1'b1; end
            4'd7:  begin d.fs = 5'b01100; d.we = 1'b1; d.setf = 1'b1; end
            4'd8:  begin d.fs = 5'b01110; d.c0 = 1'b1; d.we = 1'b1; d.setf = 1'b1; end
            4'd9:  begin d.fs = 5'b00000; d.we = 1'b1; d.setf = 1'b1; d.logic_flags = 1'b1; end
            4'd10: begin d.fs = 5'b01110; d.c0 = 1'b1; d.setf = 1'b1; end
            4'd11: d.bcond = 1'b1;
            default: d.illegal = 1'b1;
        endcase
        return d;
    endfunction

    // f is {V,C,N,Z}
    function automatic logic cond_eval(input logic [3:0] cc, input logic [3:0] f);
        logic v, c, n, z;
        {v, c, n, z} = f;
        case (cc)
            4'd0:    return z;
            4'd1:    return ~z;
            4'd2:    return c;
            4'd3:    return ~c;
            4'd4:    return n;
            4'd5:    return ~n;
            4'd6:    return v;
            4'd7:    return ~v;
            4'd8:    return c & ~z;
            4'd9:    return ~c | z;
            4'd10:   return n == v;
            4'd11:   return n != v;
            4'd12:   return ~z & (n == v);
            4'd13:   return z | (n != v);
            default: return 1'b1;
        endcase
    endfunction

    state_t       r_state, w_next;
    dec_t         r_dec;
    logic [3:0]   r_cond;
    logic [W-1:0] r_alu_a, r_alu_b;
    logic [W-1:0] r_result;
    logic         r_we, r_taken, r_err;
    logic [3:0]   r_flags;
    logic         w_req_ready, w_rsp_valid, w_accept;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next      = r_state;
        w_req_ready = 1'b0;
        w_rsp_valid = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_req_ready = 1'b1;
                if (bus.req_valid) w_next = S_EXEC;
            end
            S_EXEC: w_next = S_RESP;
            S_RESP: begin
                w_rsp_valid = 1'b1;
                if (bus.rsp_ready) w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    assign w_accept = bus.req_valid & w_req_ready;

    // The decoded control word is kept whole: FS/C0 drive the ALU, the rest steers EXEC.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_dec    <= '0;
            r_cond   <= '0;
            r_alu_a  <= '0;
            r_alu_b  <= '0;
            r_result <= '0;
            r_we     <= 1'b0;
            r_taken  <= 1'b0;
            r_err    <= 1'b0;
            r_flags  <= '0;
        end else begin
            if (w_accept) begin
                r_dec   <= decode(bus.req_op);
                r_cond  <= bus.req_cond;
                r_alu_a <= bus.req_a;
                r_alu_b <= bus.req_b;
            end
            if (r_state == S_EXEC) begin
                r_result <= (r_dec.bcond | r_dec.illegal) ? '0 : bus.alu_f;
                r_we     <= r_dec.we;
                r_err    <= r_dec.illegal;
                r_taken  <= r_dec.bcond & cond_eval(r_cond, r_flags);
                if (r_dec.setf)
                    r_flags <= r_dec.logic_flags ? {2'b00, bus.alu_status[1:0]} : bus.alu_status;
            end
        end
    end

    assign bus.req_ready  = w_req_ready;
    assign bus.rsp_valid  = w_rsp_valid;
    assign bus.alu_a      = r_alu_a;
    assign bus.alu_b      = r_alu_b;
    assign bus.alu_fs     = r_dec.fs;
    assign bus.alu_c0     = r_dec.c0;
    assign bus.rsp_result = r_result;
    assign bus.rsp_we     = r_we;
    assign bus.rsp_taken  = r_taken;
    assign bus.rsp_err    = r_err;
    assign flags          = r_flags;
endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Bench for alu_issue_ctrl: behavioural ALU stand-in plus an op-level reference model
// (plain arithmetic on A/B) for results, flags and branch outcomes.
module tb_alu_issue_ctrl;
    localparam int W = 64;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] flags;
    int         checks = 0;
    int         errors = 0;
    logic [3:0] m_flags = 4'b0000;

    alu_issue_ctrl_if #(.W(W)) bus ();

    alu_issue_ctrl #(.W(W)) dut (
        .clock (clk),
        .reset (rst),
        .bus   (bus),
        .flags (flags)
    );

    always #5 clk = ~clk;

    // Combinational ALU stand-in driven by FS/C0 exactly as the ALU defines them
    logic [W-1:0] sa, sb, sf;
    logic [W:0]   ssum;
    logic         sv, sc;
    always_comb begin
        sa   = bus.alu_fs[0] ? ~bus.alu_a : bus.alu_a;
        sb   = bus.alu_fs[1] ? ~bus.alu_b : bus.alu_b;
        ssum = {1'b0, sa} + {1'b0, sb} + {{W{1'b0}}, bus.alu_c0};
        sf   = '0;
        sc   = 1'b0;
        sv   = 1'b0;
        case (bus.alu_fs[4:2])
            3'b000: sf = sa & sb;
            3'b001: sf = sa | sb;
            3'b010: sf = sa ^ sb;
            3'b011: begin
                sf = ssum[W-1:0];
                sc = ssum[W];
                sv = (sa[W-1] == sb[W-1]) && (sf[W-1] != sa[W-1]);
            end
            3'b100: sf = sa << sb[5:0];
            3'b101: sf = sa >> sb[5:0];
            default: sf = '0;
        endcase
        bus.alu_f      = sf;
        bus.alu_status = {sv, sc, sf[W-1], sf == '0};
    end

    function automatic logic cond_true(input logic [3:0] cc, input logic [3:0] f);
        logic v, c, n, z;
        v = f[3]; c = f[2]; n = f[1]; z = f[0];
        case (cc)
            0: return z == 1'b1;
            1: return z == 1'b0;
            2: return c == 1'b1;
            3: return c == 1'b0;
            4: return n == 1'b1;
            5: return n == 1'b0;
            6: return v == 1'b1;
            7: return v == 1'b0;
            8: return c && !z;
            9: return !c || z;
            10: return n == v;
            11: return n != v;
            12: return !z && (n == v);
            13: return z || (n != v);
            default: return 1'b1;
        endcase
    endfunction

    // Reference: op semantics on plain integers; updates m_flags like the architecture would
    task automatic model(input logic [3:0] op, input logic [3:0] cc, input logic [W-1:0] a,
                         input logic [W-1:0] b, output logic [W-1:0] r, output logic we,
                         output logic tk, output logic er);
        logic [W:0] wide;
        logic v, c;
        r = '0; we = 1'b0; tk = 1'b0; er = 1'b0;
        case (op)
            0: begin r = a + b; we = 1'b1; end
            1: begin r = a - b; we = 1'b1; end
            2: begin r = a & b; we = 1'b1; end
            3: begin r = a | b; we = 1'b1; end
            4: begin r = a ^ b; we = 1'b1; end
            5: begin r = a << b[5:0]; we = 1'b1; end
            6: begin r = a >> b[5:0]; we = 1'b1; end
            7: begin
                wide = {1'b0, a} + {1'b0, b};
                r = wide[W-1:0]; c = wide[W];
                v = (a[W-1] == b[W-1]) && (r[W-1] != a[W-1]);
                m_flags = {v, c, r[W-1], r == '0};
                we = 1'b1;
            end
            8, 10: begin
                r = a - b; c = (a >= b);
                v = (a[W-1] != b[W-1]) && (r[W-1] != a[W-1]);
                m_flags = {v, c, r[W-1], r == '0};
                we = (op == 8);
                if (op == 10) r = a - b;
            end
            9: begin r = a & b; m_flags = {2'b00, r[W-1], r == '0}; we = 1'b1; end
            11: tk = cond_true(cc, m_flags);
            default: er = 1'b1;
        endcase
        if (op == 10) we = 1'b0;
    endtask

    // Drives one request, waits (bounded) for the response, optionally stalls rsp_ready.
    task automatic run_op(input logic [3:0] op, input logic [3:0] cc, input logic [W-1:0] a,
                          input logic [W-1:0] b, input int hold, output int lat,
                          output logic [W-1:0] res, output logic we, output logic tk,
                          output logic er, output logic [4:0] fs, output logic stable);
        @(negedge clk);
        bus.req_valid = 1'b1; bus.req_op = op; bus.req_cond = cc; bus.req_a = a; bus.req_b = b;
        @(posedge clk); #1;
        bus.req_valid = 1'b0; bus.req_op = 'x; bus.req_a = 'x; bus.req_b = 'x;
        fs = bus.alu_fs;
        lat = 0;
        while (!bus.rsp_valid && lat < 10) begin
            @(posedge clk); #1; lat++;
        end
        res = bus.rsp_result; we = bus.rsp_we; tk = bus.rsp_taken; er = bus.rsp_err;
        stable = 1'b1;
        repeat (hold) begin
            @(posedge clk); #1;
            if (!bus.rsp_valid || bus.req_ready || bus.rsp_result !== res || bus.rsp_we !== we ||
                bus.rsp_taken !== tk || bus.rsp_err !== er || bus.alu_fs !== fs)
                stable = 1'b0;
        end
        bus.rsp_ready = 1'b1;
        @(posedge clk); #1;
        bus.rsp_ready = 1'b0;
    endtask

    int          lat;
    logic [W-1:0] res, e_res;
    logic        we, tk, er, e_we, e_tk, e_er, stable;
    logic [4:0]  fs;

    task automatic test_reset();
        repeat (3) @(posedge clk);
        #1;
        checks++; if (bus.req_ready !== 1'b1) begin errors++; $display("FAIL reset_req_ready got %b want 1", bus.req_ready); end
        checks++; if (bus.rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid got %b want 0", bus.rsp_valid); end
        checks++; if ({flags, bus.alu_fs, bus.alu_c0} !== 10'd0) begin errors++; $display("FAIL reset_ctrl got %b want 0", {flags, bus.alu_fs, bus.alu_c0}); end
        checks++; if ({bus.alu_a, bus.alu_b, bus.rsp_result} !== '0) begin errors++; $display("FAIL reset_data got nonzero want 0"); end
        checks++; if ({bus.rsp_we, bus.rsp_taken, bus.rsp_err} !== 3'b000) begin errors++; $display("FAIL reset_rsp_bits got %b want 000", {bus.rsp_we, bus.rsp_taken, bus.rsp_err}); end
        @(negedge clk); rst = 1'b0; m_flags = 4'b0000;
    endtask

    task automatic test_subs_zero();
        model(4'd8, 4'd0, 64'd5, 64'd5, e_res, e_we, e_tk, e_er);
        run_op(4'd8, 4'd0, 64'd5, 64'd5, 0, lat, res, we, tk, er, fs, stable);
        checks++; if (lat !== 1) begin errors++; $display("FAIL subs_latency got %0d edges want 1", lat); end
        checks++; if (res !== e_res || we !== e_we) begin errors++; $display("FAIL subs_result got %h/%b want %h/%b", res, we, e_res, e_we); end
        checks++; if (flags !== m_flags) begin errors++; $display("FAIL subs_flags got %b want %b", flags, m_flags); end
        checks++; if (bus.req_ready !== 1'b1 || bus.rsp_valid !== 1'b0) begin errors++; $display("FAIL subs_return_idle got %b%b want 10", bus.req_ready, bus.rsp_valid); end
    endtask

    task automatic test_adds_overflow_bcond();
        model(4'd7, 4'd0, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, e_res, e_we, e_tk, e_er);
        run_op(4'd7, 4'd0, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 0, lat, res, we, tk, er, fs, stable);
        checks++; if (res !== e_res) begin errors++; $display("FAIL adds_result got %h want %h", res, e_res); end
        checks++; if (flags !== m_flags) begin errors++; $display("FAIL adds_flags got %b want %b", flags, m_flags); end
        model(4'd11, 4'd6, 64'd0, 64'd0, e_res, e_we, e_tk, e_er);
        run_op(4'd11, 4'd6, 64'd0, 64'd0, 0, lat, res, we, tk, er, fs, stable);
        checks++; if (tk !== e_tk || res !== 64'd0 || we !== 1'b0) begin errors++; $display("FAIL bcond_vs got tk=%b res=%h we=%b want tk=%b", tk, res, we, e_tk); end
        checks++; if (flags !== m_flags) begin errors++; $display("FAIL bcond_vs_flags got %b want %b", flags, m_flags); end
    endtask

    task automatic test_cmp_bcond();
        model(4'd10, 4'd0, 64'd3, 64'd7, e_res, e_we, e_tk, e_er);
        run_op(4'd10, 4'd0, 64'd3, 64'd7, 0, lat, res, we, tk, er, fs, stable);
        checks++; if (we !== 1'b0 || flags !== m_flags) begin errors++; $display("FAIL cmp got we=%b flags=%b want we=0 flags=%b", we, flags, m_flags); end
        for (int k = 0; k < 2; k++) begin
            logic [3:0] cc;
            cc = (k == 0) ? 4'd11 : 4'd10;
            model(4'd11, cc, 64'd0, 64'd0, e_res, e_we, e_tk, e_er);
            run_op(4'd11, cc, 64'd0, 64'd0, 0, lat, res, we, tk, er, fs, stable);
            checks++; if (tk !== e_tk) begin errors++; $display("FAIL cmp_bcond_c%0d got %b want %b", cc, tk, e_tk); end
        end
    endtask

    task automatic test_lsl_backpressure();
        model(4'd5, 4'd0, 64'd1, 64'h43, e_res, e_we, e_tk, e_er);
        run_op(4'd5, 4'd0, 64'd1, 64'h43, 4, lat, res, we, tk, er, fs, stable);
        checks++; if (res !== e_res || fs !== 5'b10000) begin errors++; $display("FAIL lsl got %h fs=%b want %h fs=10000", res, fs, e_res); end
        checks++; if (stable !== 1'b1) begin errors++; $display("FAIL lsl_hold_stable got %b want 1", stable); end
        checks++; if (flags !== m_flags) begin errors++; $display("FAIL lsl_flags got %b want %b", flags, m_flags); end
    endtask

    task automatic test_ands_illegal();
        model(4'd9, 4'd0, 64'h8000_0000_0000_0001, 64'h8000_0000_0000_0000, e_res, e_we, e_tk, e_er);
        run_op(4'd9, 4'd0, 64'h8000_0000_0000_0001, 64'h8000_0000_0000_0000, 0, lat, res, we, tk, er, fs, stable);
        checks++; if (res !== e_res || flags !== m_flags) begin errors++; $display("FAIL ands got %h/%b want %h/%b", res, flags, e_res, m_flags); end
        model(4'd13, 4'd0, 64'd9, 64'd9, e_res, e_we, e_tk, e_er);
        run_op(4'd13, 4'd0, 64'd9, 64'd9, 0, lat, res, we, tk, er, fs, stable);
        checks++; if ({er, we} !== {e_er, e_we} || res !== e_res) begin errors++; $display("FAIL illegal got err=%b we=%b res=%h want %b %b %h", er, we, res, e_er, e_we, e_res); end
        checks++; if (flags !== m_flags) begin errors++; $display("FAIL illegal_flags got %b want %b", flags, m_flags); end
    endtask

    task automatic test_back_to_back();
        int accepts;
        accepts = 0;
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        bus.req_valid = 1'b1; bus.req_op = 4'd0; bus.req_cond = 4'd0;
        bus.req_a = 64'd11; bus.req_b = 64'd22;
        for (int i = 0; i < 12; i++) begin
            if (bus.req_ready) accepts++;
            @(posedge clk); @(negedge clk);
        end
        bus.req_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        bus.rsp_ready = 1'b0;
        checks++; if (accepts !== 4) begin errors++; $display("FAIL back_to_back accepts got %0d want 4", accepts); end
        checks++; if (bus.rsp_result !== 64'd33 || flags !== m_flags) begin errors++; $display("FAIL back_to_back_last got %h/%b want 33/%b", bus.rsp_result, flags, m_flags); end
    endtask

    task automatic test_random();
        int bad;
        logic [3:0]   op, cc;
        logic [W-1:0] a, b;
        logic [4:0]   e_fs;
        logic [4:0]   fs_tab [0:11];
        fs_tab = '{5'b01100, 5'b01110, 5'b00000, 5'b00100, 5'b01000, 5'b10000,
                   5'b10100, 5'b01100, 5'b01110, 5'b00000, 5'b01110, 5'b00000};
        for (int n = 0; n < 60; n++) begin
            op = 4'($urandom_range(0, 15));
            cc = 4'($urandom_range(0, 15));
            a  = {$urandom, $urandom};
            b  = ($urandom_range(0, 3) == 0) ? a : {$urandom, $urandom};
            if ($urandom_range(0, 3) == 0) a[W-1] = ~a[W-1];
            model(op, cc, a, b, e_res, e_we, e_tk, e_er);
            run_op(op, cc, a, b, $urandom_range(0, 2), lat, res, we, tk, er, fs, stable);
            e_fs = (op < 4'd12) ? fs_tab[op] : fs;
            bad = 0;
            if (lat !== 1) bad |= 1;
            if (res !== e_res) bad |= 2;
            if ({we, tk, er} !== {e_we, e_tk, e_er}) bad |= 4;
            if (flags !== m_flags) bad |= 8;
            if (fs !== e_fs || stable !== 1'b1) bad |= 16;
            checks++;
            if (bad != 0) begin
                errors++;
                $display("FAIL random[%0d] op=%0d cc=%0d code=%0d got res=%h wte=%b%b%b fl=%b fs=%b lat=%0d want res=%h wte=%b%b%b fl=%b fs=%b lat=1",
                         n, op, cc, bad, res, we, tk, er, flags, fs, lat, e_res, e_we, e_tk, e_er, m_flags, e_fs);
            end
        end
    endtask

    task automatic test_reset_mid_exec();
        int seen;
        seen = 0;
        @(negedge clk);
        bus.req_valid = 1'b1; bus.req_op = 4'd8; bus.req_cond = 4'd0;
        bus.req_a = 64'd1; bus.req_b = 64'd2;
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        rst = 1'b1;
        #1;
        checks++; if (bus.rsp_valid !== 1'b0 || bus.req_ready !== 1'b1) begin errors++; $display("FAIL midreset_handshake got v=%b r=%b want 0 1", bus.rsp_valid, bus.req_ready); end
        checks++; if (flags !== 4'b0000 || bus.alu_fs !== 5'b00000) begin errors++; $display("FAIL midreset_state got flags=%b fs=%b want 0", flags, bus.alu_fs); end
        @(negedge clk); rst = 1'b0; m_flags = 4'b0000;
        bus.rsp_ready = 1'b1;
        repeat (6) begin
            @(posedge clk); #1;
            if (bus.rsp_valid) seen++;
        end
        bus.rsp_ready = 1'b0;
        checks++; if (seen !== 0) begin errors++; $display("FAIL midreset_no_response got %0d responses want 0", seen); end
    endtask

    initial begin
        bus.req_valid = 1'b0; bus.req_op = '0; bus.req_cond = '0;
        bus.req_a = '0; bus.req_b = '0; bus.rsp_ready = 1'b0;
        test_reset();
        test_subs_zero();
        test_adds_overflow_bcond();
        test_cmp_bcond();
        test_lsl_backpressure();
        test_ands_illegal();
        test_back_to_back();
        test_random();
        test_reset_mid_exec();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
